mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined core, directly downstream of the EX/MEM latch. It takes the EX/MEM latch outputs, issues the data-cache request and holds it until `dhit`, and stalls the upstream pipeline while a miss is outstanding. It selects the write-back value and registers the MEM/WB latch that feeds the register-file write port. It also retires `halt` cleanly and flags memory accesses that hang.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 0: miss-wait watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `port_out_i` in word_t: ALU result, also the data address.
- `rdat2_i` in word_t: store data.
- `zeroExt_i` in word_t: upper-immediate value.
- `npc_i` in word_t: PC+4, the link value.
- `rd_i` in regbits_t: destination register.
- `regWr_i`, `dREN_i`, `dWEN_i`, `datomic_i`, `halt_i` in 1: EX/MEM control bits.
- `rdSel_i` in 3: write-back source select.
- `ex_adv_i` in 1: EX/MEM latch loads a new instruction this cycle.
- `dhit` in 1: dcache completion.
- `dmemload` in word_t: load data.
- `dmemREN`, `dmemWEN`, `datomic` out 1: dcache request.
- `dmemaddr`, `dmemstore` out word_t: dcache request address and store data.
- `stall_o` out 1: freeze IF through EX/MEM.
- `wdat_o` out word_t: MEM/WB write-back data.
- `rd_o` out regbits_t: MEM/WB destination register.
- `regWr_o`, `halt_o` out 1: MEM/WB control.
- `timeout_o` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, WAIT, DONE, HALTED.
- A memory op exists when `dREN_i|dWEN_i`. If both are high, the op is a store: `dmemWEN`=1, `dmemREN`=0.
- Request outputs are combinational from the inputs and are forced to 0 in DONE, in HALTED, and while `RST` is high.
- `dmemaddr`=`port_out_i`, `dmemstore`=`rdat2_i`, `datomic`=`datomic_i` gated by the request.
- `stall_o` = memory op & ~`dhit` & state in {IDLE, WAIT}.
- IDLE:
  - Op with `dhit` (same-cycle hit): capture into MEM/WB; stay IDLE if `ex_adv_i`, else go to DONE.
  - Op without `dhit`: go to WAIT.
  - No op: capture the instruction, which may have `regWr`.
- WAIT: on `dhit`, capture; next state is IDLE if `ex_adv_i`, else DONE. Otherwise remain in WAIT and increment the watchdog counter.
- DONE: the instruction has completed but EX/MEM is still held. Suppress the request and load bubbles into MEM/WB. Return to IDLE when `ex_adv_i`=1.
- Bubble: `regWr_o`=0, `halt_o`=0, `rd_o`=0, `wdat_o`=0. MEM/WB loads a bubble every cycle the stage is stalled.
- Write-back select on capture:
  - 0: `port_out_i`.
  - 1: `dmemload`.
  - 2: `npc_i`.
  - 3: `zeroExt_i`.
  - 4–7: `port_out_i`.
- Halt: a captured `halt_i`=1 sets `halt_o`=1 and moves to HALTED. HALTED is absorbing until `RST`: no requests, `stall_o`=0, `halt_o` held at 1, `regWr_o` held at 0.
- Watchdog (`TIMEOUT_CYCLES`>0):
  - Counter of width $clog2(`TIMEOUT_CYCLES`+1), saturating.
  - Cleared on entry to WAIT.
  - When the count reaches `TIMEOUT_CYCLES`, `timeout_o` is set and stays set until `RST`. The stage keeps waiting.

## Timing
- Reset values: state IDLE, counter 0, and all registered outputs (`wdat_o`, `rd_o`, `regWr_o`, `halt_o`, `timeout_o`) are 0.
- Reset asserted mid-WAIT: the request drops in the same cycle and the state is IDLE after the edge.
- Latency:
  - Non-memory op: result in MEM/WB one edge after it appears at the inputs.
  - Load/store whose `dhit` arrives N cycles after the request (N=0 for a same-cycle hit): visible after N+1 edges.
  - `stall_o` is high for exactly N cycles.
- `dhit` in IDLE/WAIT with no memory op is ignored. `dhit` in DONE or HALTED is ignored.
- Simultaneous events:
  - `halt_i` on a memory op: the op completes first, then the stage halts.
  - `dhit` on the same cycle the counter saturates: both the capture and the flag set take effect.

## Structure
- `cpu_types_pkg` holds:
  - `word_t` and `regbits_t` (existing).
  - A new enum `wbsel_t` for the `rdSel` codes 0–3.
  - A new `memstage_state_t` for the FSM state.
- One natural sub-module, `mem_wb_latch`: the MEM/WB register with `load` and `bubble` controls and synchronous reset.
- The FSM, request gating, write-back mux and watchdog stay in `mem_stage`.

## Test plan
- Load, `port_out_i`=0x100, `rdSel_i`=1, `dhit` 3 cycles after request, `dmemload`=0xDEADBEEF → `stall_o` high 3 cycles; `wdat_o`=0xDEADBEEF with `regWr_o`=1 on edge 4. MEM/WB holds bubbles during the stall.
- Store, same-cycle `dhit`, `rdat2_i`=0x55 → `dmemWEN`=1 for exactly 1 cycle, `stall_o` never high, `dmemstore`=0x55.
- `dhit` with `ex_adv_i`=0 for 2 cycles → DONE; no re-issued request; 2 bubbles; back to IDLE when `ex_adv_i` rises.
- `halt_i`=1 on a non-memory instruction, then a load presented → `halt_o`=1 held; `dmemREN` stays 0.
- `TIMEOUT_CYCLES`=4, `dhit` withheld 10 cycles → `timeout_o` rises after the 4th WAIT cycle and stays high after `dhit`.
- `RST` asserted in WAIT → `dmemREN`=0 the same cycle; all outputs 0 after the edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared core types: data word, register index, write-back source codes and
// the memory-stage FSM state.
// No ports; imported by the memory stage, its interface and its MEM/WB latch.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // rdSel codes 4..7 are unused by the decoder and fall back to the ALU result.
  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_LOAD = 3'd1,
    WB_NPC  = 3'd2,
    WB_IMM  = 3'd3
  } wbsel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } memstage_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the memory stage and the dcache.
// master (stage): drives dmemREN/dmemWEN/datomic/dmemaddr/dmemstore, sees dhit/dmemload.
// slave (cache): the mirror image.
interface mem_stage_if;
  import cpu_types_pkg::*;

  logic  dhit;
  word_t dmemload;
  logic  dmemREN;
  logic  dmemWEN;
  logic  datomic;
  word_t dmemaddr;
  word_t dmemstore;

  modport master (
    input  dhit, dmemload,
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore
  );

  modport slave (
    output dhit, dmemload,
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore
  );

endinterface

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: load captures the inputs, bubble clears to a no-op.
// Latency: one edge. Backpressure: none; the controller decides every cycle.
// Ports: CLK/RST (sync, active-high), load/bubble controls, write-back data, rd, regWr, halt.
module mem_wb_latch
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     load,
  input  logic     bubble,
  input  word_t    wdatIn,
  input  regbits_t rdIn,
  input  logic     regWrIn,
  input  logic     haltIn,
  output word_t    wdat,
  output regbits_t rd,
  output logic     regWr,
  output logic     halt
);

  // Bubble wins over load so a stalled cycle can never leak a half-finished op.
  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      wdat  <= '0;
      rd    <= '0;
      regWr <= 1'b0;
      halt  <= 1'b0;
    end else if (load) begin
      wdat  <= wdatIn;
      rd    <= rdIn;
      regWr <= regWrIn;
      halt  <= haltIn;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues the dcache request, stalls upstream on a miss, muxes write-back data into MEM/WB.
// Latency: non-memory op 1 edge; memory op N+1 edges where N = cycles from request to dhit.
// Backpressure: stall_o freezes IF..EX/MEM while a miss is outstanding; MEM/WB gets bubbles meanwhile.
// Ports: CLK/RST (sync, active-high), EX/MEM inputs (*_i), ex_adv_i, dcif (dcache master),
//        stall_o, MEM/WB outputs (wdat_o, rd_o, regWr_o, halt_o), sticky timeout_o.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  word_t             port_out_i,
  input  word_t             rdat2_i,
  input  word_t             zeroExt_i,
  input  word_t             npc_i,
  input  regbits_t          rd_i,
  input  logic              regWr_i,
  input  logic              dREN_i,
  input  logic              dWEN_i,
  input  logic              datomic_i,
  input  logic              halt_i,
  input  logic [2:0]        rdSel_i,
  input  logic              ex_adv_i,
  mem_stage_if.master       dcif,
  output logic              stall_o,
  output word_t             wdat_o,
  output regbits_t          rd_o,
  output logic              regWr_o,
  output logic              halt_o,
  output logic              timeout_o
);

  // A zero limit disables the watchdog; keep the counter one bit wide so it still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  memstage_state_t state, nextState;
  logic [CW-1:0]   waitCnt;

  logic  memOp, inFlight, reqOn;
  word_t wbDat;
  logic  latchLoad, latchBubble;
  word_t ldWdat;
  regbits_t ldRd;
  logic  ldRegWr, ldHalt;
  logic  cntInc, cntClr;

  assign memOp    = dREN_i | dWEN_i;
  assign inFlight = (state == IDLE) || (state == WAIT);
  assign reqOn    = memOp & inFlight & ~RST;

  // Both enables high means an atomic-style store: write wins.
  assign dcif.dmemREN   = reqOn & dREN_i & ~dWEN_i;
  assign dcif.dmemWEN   = reqOn & dWEN_i;
  assign dcif.datomic   = reqOn & datomic_i;
  assign dcif.dmemaddr  = port_out_i;
  assign dcif.dmemstore = rdat2_i;

  assign stall_o = memOp & ~dcif.dhit & inFlight;

  always_comb begin
    wbDat = port_out_i;
    case (rdSel_i)
      WB_LOAD: wbDat = dcif.dmemload;
      WB_NPC:  wbDat = npc_i;
      WB_IMM:  wbDat = zeroExt_i;
      default: wbDat = port_out_i;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState   = state;
    latchLoad   = 1'b0;
    latchBubble = 1'b0;
    ldWdat      = wbDat;
    ldRd        = rd_i;
    ldRegWr     = regWr_i;
    ldHalt      = halt_i;
    cntInc      = 1'b0;
    cntClr      = 1'b0;
    case (state)
      IDLE: begin
        if (memOp && !dcif.dhit) begin
          nextState   = WAIT;
          latchBubble = 1'b1;
          cntClr      = 1'b1;
        end else begin
          latchLoad = 1'b1;
          if (halt_i)                 nextState = HALTED;
          else if (memOp && !ex_adv_i) nextState = DONE;
        end
      end
      WAIT: begin
        // Every WAIT cycle counts, including the one the hit lands on.
        cntInc = 1'b1;
        if (dcif.dhit) begin
          latchLoad = 1'b1;
          if (halt_i)         nextState = HALTED;
          else if (ex_adv_i)  nextState = IDLE;
          else                nextState = DONE;
        end else begin
          latchBubble = 1'b1;
        end
      end
      DONE: begin
        // EX/MEM still shows the finished op; keep MEM/WB empty until it moves on.
        latchBubble = 1'b1;
        if (ex_adv_i) nextState = IDLE;
      end
      HALTED: begin
        // Hold the halting result but stop any further register write.
        latchLoad = 1'b1;
        ldWdat    = wdat_o;
        ldRd      = rd_o;
        ldRegWr   = 1'b0;
        ldHalt    = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || cntClr)
      waitCnt <= '0;
    else if (cntInc && waitCnt != CW'(TIMEOUT_CYCLES))
      waitCnt <= waitCnt + 1'b1;
  end

  // Flag on the edge where the count reaches the limit; the stage keeps waiting.
  always_ff @(posedge CLK) begin
    if (RST)
      timeout_o <= 1'b0;
    else if ((TIMEOUT_CYCLES > 0) && cntInc && (int'(waitCnt) + 1 >= TIMEOUT_CYCLES))
      timeout_o <= 1'b1;
  end

  mem_wb_latch u_memWb (
    .CLK     (CLK),
    .RST     (RST),
    .load    (latchLoad),
    .bubble  (latchBubble),
    .wdatIn  (ldWdat),
    .rdIn    (ldRd),
    .regWrIn (ldRegWr),
    .haltIn  (ldHalt),
    .wdat    (wdat_o),
    .rd      (rd_o),
    .regWr   (regWr_o),
    .halt    (halt_o)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model of the stage.
module tb_mem_stage;
  import cpu_types_pkg::*;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  word_t      port_out_i, rdat2_i, zeroExt_i, npc_i;
  regbits_t   rd_i;
  logic       regWr_i, dREN_i, dWEN_i, datomic_i, halt_i;
  logic [2:0] rdSel_i;
  logic       ex_adv_i;
  logic       stall_o;
  word_t      wdat_o;
  regbits_t   rd_o;
  logic       regWr_o, halt_o, timeout_o;

  mem_stage_if dc();

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .port_out_i(port_out_i), .rdat2_i(rdat2_i), .zeroExt_i(zeroExt_i), .npc_i(npc_i),
    .rd_i(rd_i), .regWr_i(regWr_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
    .datomic_i(datomic_i), .halt_i(halt_i), .rdSel_i(rdSel_i), .ex_adv_i(ex_adv_i),
    .dcif(dc.master), .stall_o(stall_o),
    .wdat_o(wdat_o), .rd_o(rd_o), .regWr_o(regWr_o), .halt_o(halt_o), .timeout_o(timeout_o)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nPass   = 0;
  int stallCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: what the stage owes the pipeline, tracked as transaction facts.
  bit       mWaiting, mDone, mHalted, mTimeout;
  word_t    mWdat;
  regbits_t mRd;
  bit       mRegWr, mHalt;
  int       mWaitCycles;

  function automatic word_t expWb();
    case (rdSel_i)
      3'd1:    return dc.dmemload;
      3'd2:    return npc_i;
      3'd3:    return zeroExt_i;
      default: return port_out_i;
    endcase
  endfunction

  function automatic bit expStall();
    return (dREN_i | dWEN_i) && !dc.dhit && !mDone && !mHalted;
  endfunction

  task automatic modelBubble();
    mWdat = '0; mRd = '0; mRegWr = 0; mHalt = 0;
  endtask

  task automatic modelWaitTick();
    mWaitCycles++;
    if (mWaitCycles >= TO) mTimeout = 1;
  endtask

  task automatic modelEdge();
    bit op;
    op = dREN_i | dWEN_i;
    if (RST) begin
      mWaiting = 0; mDone = 0; mHalted = 0; mTimeout = 0; mWaitCycles = 0;
      modelBubble();
    end else if (mHalted) begin
      mRegWr = 0;
    end else if (mDone) begin
      modelBubble();
      if (ex_adv_i) mDone = 0;
    end else if (op && !dc.dhit) begin
      modelBubble();
      if (mWaiting) modelWaitTick();
      else begin mWaiting = 1; mWaitCycles = 0; end
    end else begin
      if (mWaiting) modelWaitTick();
      mWdat = expWb(); mRd = rd_i; mRegWr = regWr_i; mHalt = halt_i;
      mWaiting = 0;
      if (halt_i) mHalted = 1;
      else if (op && !ex_adv_i) mDone = 1;
    end
  endtask

  task automatic checkComb();
    bit req;
    req = !RST && !mDone && !mHalted && (dREN_i | dWEN_i);
    checkVal("dmemREN",   dc.dmemREN, req && dREN_i && !dWEN_i);
    checkVal("dmemWEN",   dc.dmemWEN, req && dWEN_i);
    checkVal("datomic",   dc.datomic, req && datomic_i);
    checkVal("dmemaddr",  dc.dmemaddr, port_out_i);
    checkVal("dmemstore", dc.dmemstore, rdat2_i);
    checkVal("stall_o",   stall_o, expStall());
  endtask

  task automatic checkRegs();
    checkVal("wdat_o",    wdat_o, mWdat);
    checkVal("rd_o",      rd_o, mRd);
    checkVal("regWr_o",   regWr_o, mRegWr);
    checkVal("halt_o",    halt_o, mHalt);
    checkVal("timeout_o", timeout_o, mTimeout);
  endtask

  // Called 1 time unit after a rising edge with the inputs for this cycle already applied.
  task automatic cycle();
    #2;
    checkComb();
    if (stall_o) stallCount++;
    @(posedge CLK);
    modelEdge();
    #1;
    checkRegs();
  endtask

  task automatic setInstr(input bit ren, input bit wen, input word_t addr, input word_t st,
                          input logic [2:0] sel, input bit wr, input bit hlt);
    dREN_i = ren; dWEN_i = wen; port_out_i = addr; rdat2_i = st; rdSel_i = sel;
    regWr_i = wr; halt_i = hlt; datomic_i = 1'b0;
    rd_i = regbits_t'($urandom_range(1, 31));
    npc_i = $urandom; zeroExt_i = $urandom;
  endtask

  task automatic randInstr();
    int kind;
    kind = $urandom_range(0, 3);
    dREN_i    = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
    dWEN_i    = (kind == 3);
    halt_i    = ($urandom_range(0, 29) == 0);
    datomic_i = $urandom_range(0, 1);
    regWr_i   = $urandom_range(0, 1);
    rdSel_i   = 3'($urandom_range(0, 7));
    rd_i      = regbits_t'($urandom_range(0, 31));
    port_out_i = $urandom; rdat2_i = $urandom; npc_i = $urandom; zeroExt_i = $urandom;
  endtask

  initial begin
    setInstr(0, 0, 32'h0, 32'h0, 3'd0, 0, 0);
    dc.dhit = 1'b0; dc.dmemload = '0; ex_adv_i = 1'b0; RST = 1'b1;
    #1;
    cycle();                               // reset state

    // Load missing for 3 cycles
    RST = 1'b0;
    setInstr(1, 0, 32'h100, 32'h0, 3'd1, 1, 0);
    stallCount = 0;
    repeat (3) cycle();
    dc.dhit = 1'b1; dc.dmemload = 32'hDEADBEEF; ex_adv_i = 1'b1;
    cycle();
    checkVal("load_stall_cycles", stallCount, 3);
    checkVal("load_wdat", wdat_o, 32'hDEADBEEF);
    checkVal("load_regWr", regWr_o, 1);

    // Store with same-cycle hit
    setInstr(0, 1, 32'h200, 32'h55, 3'd0, 0, 0);
    stallCount = 0;
    #1;
    checkVal("store_wen", dc.dmemWEN, 1);
    checkVal("store_data", dc.dmemstore, 32'h55);
    cycle();
    setInstr(0, 0, 32'h204, 32'h0, 3'd0, 1, 0);
    dc.dhit = 1'b0;
    #1;
    checkVal("store_wen_one_cycle", dc.dmemWEN, 0);
    checkVal("store_no_stall", stallCount, 0);
    cycle();

    // Hit while EX/MEM holds: two DONE cycles of bubbles, no re-issue
    setInstr(1, 0, 32'h300, 32'h0, 3'd1, 1, 0);
    dc.dhit = 1'b1; dc.dmemload = 32'h12345678; ex_adv_i = 1'b0;
    cycle();
    repeat (2) begin
      #1;
      checkVal("done_no_req", dc.dmemREN, 0);
      cycle();
      checkVal("done_bubble", regWr_o, 0);
    end
    ex_adv_i = 1'b1;
    cycle();
    setInstr(1, 0, 32'h304, 32'h0, 3'd1, 1, 0);
    dc.dhit = 1'b0; ex_adv_i = 1'b0;
    #1;
    checkVal("idle_again_req", dc.dmemREN, 1);
    dc.dhit = 1'b1; ex_adv_i = 1'b1;
    cycle();

    // Halt, then a load is presented
    setInstr(0, 0, 32'h44, 32'h0, 3'd0, 0, 1);
    dc.dhit = 1'b0;
    cycle();
    checkVal("halt_set", halt_o, 1);
    setInstr(1, 0, 32'h400, 32'h0, 3'd1, 1, 0);
    ex_adv_i = 1'b0;
    repeat (3) begin
      #1;
      checkVal("halted_no_req", dc.dmemREN, 0);
      cycle();
      checkVal("halt_held", halt_o, 1);
    end

    // Watchdog: hit withheld for 10 cycles
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    setInstr(1, 0, 32'h500, 32'h0, 3'd1, 1, 0);
    dc.dhit = 1'b0; ex_adv_i = 1'b0;
    repeat (10) cycle();
    checkVal("timeout_set", timeout_o, 1);
    dc.dhit = 1'b1; ex_adv_i = 1'b1;
    cycle();
    checkVal("timeout_sticky", timeout_o, 1);

    // Reset in the middle of a miss
    setInstr(1, 0, 32'h600, 32'h0, 3'd1, 1, 0);
    dc.dhit = 1'b0; ex_adv_i = 1'b0;
    repeat (2) cycle();
    RST = 1'b1;
    #1;
    checkVal("rst_req_drop", dc.dmemREN, 0);
    cycle();
    checkVal("rst_wdat", wdat_o, 0);
    checkVal("rst_timeout", timeout_o, 0);
    RST = 1'b0;

    // Randomized traffic
    randInstr();
    repeat (3000) begin
      RST = ($urandom_range(0, 199) == 0) || (mHalted && $urandom_range(0, 7) == 0);
      dc.dhit = ($urandom_range(0, 2) == 0);
      dc.dmemload = $urandom;
      ex_adv_i = expStall() ? 1'b0 : 1'($urandom_range(0, 1));
      cycle();
      if (ex_adv_i || RST) randInstr();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
